project_select_ctrl: RTL and testbench
======================================

# project_select_ctrl

Wishbone-programmable activation controller for the multi-project user area. It drives the one-hot `active` vector that enables exactly one wrapped design at a time on the shared io, la, irq and Wishbone buses. It guarantees a break-before-make switch: every design is deselected for a programmable guard period before the next one is enabled. It sits in `user_project_wrapper` and replaces the raw `la_data_in[63:32]` select.

## Interface
- `NUM_PROJECTS`, default 32: width of `active`; allowed range 2..32. The ID field is 5 bits regardless.
- `BASE_ADDR`, default 32'h3000_0000: register block base; decoded on `adr[31:8]`.
- `GUARD_DEFAULT`, default 8'd16: guard count loaded at reset.
- `wb_clk_i` in, 1 bit: the only clock.
- `wb_rst_i` in, 1 bit: reset. Synchronous and active-high.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in, 1 bit each: Wishbone classic strobe, cycle and write enable.
- `wbs_sel_i` in, 4 bits: ignored. All writes are full-word.
- `wbs_adr_i` in, 32 bits: byte address. `adr[3:2]` selects the register.
- `wbs_dat_i` in, 32 bits: write data.
- `wbs_ack_o` out, 1 bit: registered acknowledge.
- `wbs_dat_o` out, 32 bits: read data. It is 0 whenever `wbs_ack_o` is 0.
- `active` out, `NUM_PROJECTS` bits: project enables. The vector is one-hot or all-zero.
- `busy` out, 1 bit: high while the controller is in GUARD.
- `switch_irq` out, 1 bit: one-cycle pulse each time a project becomes active.

## Operation
- Registers (offsets from `BASE_ADDR`):
  - 0x0 SELECT, R/W. `[4:0]` target ID, `[31]` enable. A read returns the pending target.
  - 0x4 STATUS. Read fields: `[4:0]` current ID, `[9:8]` state (0 = OFF, 1 = ON, 2 = GUARD), `[16]` err. A write with `[16]=1` clears err.
  - 0x8 GUARD, R/W. `[7:0]` guard count.
  - 0xC: reads 0, writes ignored.
- Address hit: `cyc & stb & (adr[31:8]==BASE_ADDR[31:8])`.
  - On a miss there is no ack; the bus belongs to the active design.
- FSM states:
  - OFF: `active=0`.
  - ON: `active = 1<<cur`.
  - GUARD: `active=0`; counter `cnt` counts down.
- Accepted SELECT write with ID ≥ `NUM_PROJECTS`: sets err and makes no other state change.
- Accepted SELECT write with a valid ID, in ON:
  - enable=1 with ID==cur: no-op.
  - Otherwise: pending←{en, ID}, `cnt`←GUARD, state→GUARD.
- Accepted SELECT write with a valid ID, in OFF:
  - enable=0: no-op.
  - enable=1: pending←{1, ID}, `cnt`←GUARD, state→GUARD.
- Accepted SELECT write with a valid ID, in GUARD: pending is updated; `cnt` is not restarted.
- GUARD each cycle:
  - If `cnt==0`: if pending enable, then cur←pending ID, state→ON and `switch_irq` pulses; otherwise state→OFF.
  - Else `cnt`←`cnt`−1.
- A GUARD register write takes effect on the next entry to GUARD only.
- err set and clear in the same cycle: set wins.

## Timing
- Reset values:
  - state OFF, `active=0`, `busy=0`, `switch_irq=0`.
  - `wbs_ack_o=0`, `wbs_dat_o=0`.
  - cur=0, pending=0, err=0, GUARD=`GUARD_DEFAULT`.
- Reset mid-GUARD: OFF on the next edge; no irq.
- Ack timing:
  - `wbs_ack_o` rises on the edge after the hit is sampled and is high for exactly one cycle.
  - A held strobe is not acked on consecutive cycles; a new access completes every 2 cycles.
- Write acceptance: a write is accepted at the same edge that raises ack (E0). At E0, `active` drops to 0 and `busy` rises.
- With guard count G, the new `active` bit and the `switch_irq` pulse appear at E0+G+1, and `busy` falls at the same edge. G=0 still gives a single all-zero cycle.
- Read data reflects register state at the sampling edge. STATUS during GUARD reads state=2.
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
- Reset, then read STATUS → 0x0000_0000, `active=0`, GUARD reads 0x10.
- Write SELECT=0x8000_0005 from OFF → `active=0` for 17 cycles after ack, then `active=32'h20`, one-cycle `switch_irq`, and STATUS reads 0x0000_0105.
- In ON with cur=5, write GUARD=0, then SELECT=0x8000_0009 → exactly one cycle with `active=0`, then `active=32'h200`. Rewriting SELECT=0x8000_0009 causes no glitch and no irq.
- Write SELECT=0x8000_0003 followed mid-GUARD by SELECT=0x0000_0000 → ends in OFF with no irq, at the original count expiry.
- Write SELECT=0x8000_0020 with `NUM_PROJECTS`=32 → state unchanged and STATUS[16]=1. Then write STATUS=0x0001_0000 → err=0.
- Access an address outside `BASE_ADDR[31:8]` → no ack and `wbs_dat_o=0`. Assert reset mid-GUARD → `active=0` and state OFF the next cycle.

Source files
------------

// File: rtl/project_select_ctrl.sv
// Wishbone-programmable one-hot project activation controller.
// Every switch passes through an all-zero GUARD period before the next design is enabled.
module project_select_ctrl #(
  parameter int unsigned NUM_PROJECTS  = 32,
  parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
  parameter logic [7:0]  GUARD_DEFAULT = 8'd16
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic [NUM_PROJECTS-1:0] active,
  output logic                    busy,
  output logic                    switch_irq
);

  typedef enum logic [1:0] {
    StOff   = 2'd0,
    StOn    = 2'd1,
    StGuard = 2'd2
  } state_e;

  localparam logic [1:0] RegSelect = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;
  localparam logic [1:0] RegGuard  = 2'd2;

  state_e                  state_q, state_d;
  logic [4:0]              cur_q, cur_d;
  logic                    pend_en_q, pend_en_d;
  logic [4:0]              pend_id_q, pend_id_d;
  logic                    err_q, err_d;
  logic [7:0]              guard_q, guard_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    ack_q, ack_d;
  logic [31:0]             dat_q, dat_d;
  logic [NUM_PROJECTS-1:0] active_q, active_d;
  logic                    busy_q, busy_d;
  logic                    irq_q, irq_d;

  logic        hit, wr, rd;
  logic [1:0]  reg_sel;
  logic [4:0]  wr_id;
  logic        wr_en;
  logic        id_ok;
  logic [31:0] rdata;

  logic unused_bits;
  assign unused_bits = ^{wbs_sel_i, wbs_adr_i[7:4], wbs_adr_i[1:0], wbs_dat_i[30:17],
                         wbs_dat_i[15:8], wbs_dat_i[7:6]};

  always_comb begin
    // ack_q gates the hit so a held strobe completes only every other cycle
    hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~ack_q;
    wr      = hit & wbs_we_i;
    rd      = hit & ~wbs_we_i;
    reg_sel = wbs_adr_i[3:2];
    wr_id   = wbs_dat_i[4:0];
    wr_en   = wbs_dat_i[31];
    // Bit 5 is included so that ID 32 is rejected rather than aliased to ID 0
    id_ok   = (32'(wbs_dat_i[5:0]) < NUM_PROJECTS);

    unique case (reg_sel)
      RegSelect: rdata = {pend_en_q, 26'd0, pend_id_q};
      RegStatus: rdata = {15'd0, err_q, 6'd0, state_q, 3'd0, cur_q};
      RegGuard:  rdata = {24'd0, guard_q};
      default:   rdata = 32'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    pend_en_d = pend_en_q;
    pend_id_d = pend_id_q;
    err_d     = err_q;
    guard_d   = guard_q;
    cnt_d     = cnt_q;
    irq_d     = 1'b0;
    ack_d     = hit;
    dat_d     = rd ? rdata : 32'd0;

    if (wr) begin
      unique case (reg_sel)
        RegSelect: begin
          if (!id_ok) begin
            err_d = 1'b1;
          end else begin
            unique case (state_q)
              StOn: begin
                if (!(wr_en && (wr_id == cur_q))) begin
                  pend_en_d = wr_en;
                  pend_id_d = wr_id;
                  cnt_d     = guard_q;
                  state_d   = StGuard;
                end
              end
              StOff: begin
                if (wr_en) begin
                  pend_en_d = 1'b1;
                  pend_id_d = wr_id;
                  cnt_d     = guard_q;
                  state_d   = StGuard;
                end
              end
              StGuard: begin
                pend_en_d = wr_en;
                pend_id_d = wr_id;
              end
              default: state_d = StOff;
            endcase
          end
        end
        RegStatus: begin
          if (wbs_dat_i[16]) begin
            err_d = 1'b0;
          end
        end
        RegGuard: guard_d = wbs_dat_i[7:0];
        default: ;
      endcase
    end

    // Expiry looks at the freshest pending target, including a write landing this cycle
    if (state_q == StGuard) begin
      if (cnt_q == 8'd0) begin
        if (pend_en_d) begin
          cur_d   = pend_id_d;
          state_d = StOn;
          irq_d   = 1'b1;
        end else begin
          state_d = StOff;
        end
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end

    for (int unsigned i = 0; i < NUM_PROJECTS; i++) begin
      active_d[i] = (state_d == StOn) && (cur_d == 5'(i));
    end
    busy_d = (state_d == StGuard);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= StOff;
      cur_q     <= 5'd0;
      pend_en_q <= 1'b0;
      pend_id_q <= 5'd0;
      err_q     <= 1'b0;
      guard_q   <= GUARD_DEFAULT;
      cnt_q     <= 8'd0;
      ack_q     <= 1'b0;
      dat_q     <= 32'd0;
      active_q  <= '0;
      busy_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      pend_en_q <= pend_en_d;
      pend_id_q <= pend_id_d;
      err_q     <= err_d;
      guard_q   <= guard_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      active_q  <= active_d;
      busy_q    <= busy_d;
      irq_q     <= irq_d;
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign active     = active_q;
  assign busy       = busy_q;
  assign switch_irq = irq_q;

endmodule

// File: tb/tb_project_select_ctrl.sv
// Directed plus randomized bench for project_select_ctrl against a cycle-stamped reference model.
module tb_project_select_ctrl;

  localparam logic [31:0] Base = 32'h3000_0000;
  localparam int          NumP = 32;

  logic        clk = 1'b0;
  logic        rst, stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i;
  logic        ack;
  logic [31:0] dat_o;
  logic [31:0] act;
  logic        busy, irq;

  always #5 clk = ~clk;

  project_select_ctrl dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat_i),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .active    (act),
    .busy      (busy),
    .switch_irq(irq)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: state 0=OFF 1=ON 2=GUARD; guard expiry kept as an absolute edge index
  int          t = 0;
  int          m_state, m_cur, m_pid, m_guard, m_expire;
  bit          m_pen, m_err, m_ack, m_irq;
  logic [31:0] m_dat;
  logic [31:0] last_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] r);
    logic [31:0] v;
    v = 32'd0;
    case (r)
      2'd0: v = {m_pen, 26'd0, 5'(m_pid)};
      2'd1: v = {15'd0, m_err, 6'd0, 2'(m_state), 3'd0, 5'(m_cur)};
      2'd2: v = {24'd0, 8'(m_guard)};
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  task automatic m_reset();
    m_state = 0; m_cur = 0; m_pid = 0; m_pen = 0; m_err = 0;
    m_guard = 16; m_expire = -1;
  endtask

  // Advance one clock: predict from driven inputs, then compare after the edge
  task automatic step();
    bit          hit, n_ack, n_irq;
    logic [31:0] n_dat;
    int          prev, id;
    bit          en;
    hit   = cyc && stb && (adr[31:8] == Base[31:8]) && !m_ack;
    n_ack = hit;
    n_dat = (hit && !we) ? m_read(adr[3:2]) : 32'd0;
    n_irq = 0;
    t++;
    if (rst) begin
      m_reset();
      n_ack = 0;
      n_dat = 32'd0;
    end else begin
      prev = m_state;
      if (hit && we) begin
        case (adr[3:2])
          2'd0: begin
            id = int'(dat_i[5:0]);
            en = dat_i[31];
            if (id >= NumP) m_err = 1;
            else if (prev == 2) begin
              m_pen = en; m_pid = id;
            end else if ((prev == 1 && !(en && id == m_cur)) || (prev == 0 && en)) begin
              m_pen = en; m_pid = id; m_state = 2; m_expire = t + m_guard + 1;
            end
          end
          2'd1: if (dat_i[16]) m_err = 0;
          2'd2: m_guard = int'(dat_i[7:0]);
          default: ;
        endcase
      end
      if (prev == 2 && t == m_expire) begin
        if (m_pen) begin
          m_cur = m_pid; m_state = 1; n_irq = 1;
        end else begin
          m_state = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    m_ack = n_ack; m_dat = n_dat; m_irq = n_irq;
    chk("ack", {31'd0, ack}, {31'd0, m_ack});
    chk("dat_o", dat_o, m_dat);
    chk("active", act, (m_state == 1) ? (32'd1 << m_cur) : 32'd0);
    chk("busy", {31'd0, busy}, {31'd0, m_state == 2});
    chk("switch_irq", {31'd0, irq}, {31'd0, m_irq});
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wb(input bit w, input logic [31:0] a, input logic [31:0] d);
    cyc = 1; stb = 1; we = w; adr = a; dat_i = d; sel = 4'($urandom);
    step();
    last_rd = dat_o;
    cyc = 0; stb = 0; we = 0;
    step();
  endtask

  initial begin
    int op;
    logic [31:0] d;
    rst = 1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat_i = 0;
    m_reset(); m_ack = 0; m_irq = 0; m_dat = 0;
    @(posedge clk); #1;
    idle(2);
    rst = 0;
    idle(1);

    wb(0, Base + 32'h4, 0);
    chk("status_reset", last_rd, 32'h0);
    wb(0, Base + 32'h8, 0);
    chk("guard_reset", last_rd, 32'h10);

    wb(1, Base, 32'h8000_0005);
    idle(20);
    chk("active_p5", act, 32'h20);
    wb(0, Base + 32'h4, 0);
    chk("status_on5", last_rd, 32'h0000_0105);

    wb(1, Base + 32'h8, 0);
    wb(1, Base, 32'h8000_0009);
    idle(2);
    chk("active_p9", act, 32'h200);
    wb(1, Base, 32'h8000_0009);
    idle(3);

    wb(1, Base + 32'h8, 16);
    wb(1, Base, 32'h8000_0003);
    idle(5);
    wb(1, Base, 32'h0000_0000);
    idle(20);
    wb(0, Base + 32'h4, 0);
    chk("status_off", last_rd, 32'h0000_0009);

    wb(1, Base, 32'h8000_0020);
    wb(0, Base + 32'h4, 0);
    chk("status_err", last_rd, 32'h0001_0009);
    wb(1, Base + 32'h4, 32'h0001_0000);
    wb(0, Base + 32'h4, 0);
    chk("status_errclr", last_rd, 32'h0000_0009);

    cyc = 1; stb = 1; we = 0; adr = Base + 32'h104;
    idle(3);
    chk("miss_no_ack", {31'd0, ack}, 32'd0);
    adr = Base + 32'h8;
    idle(5);
    cyc = 0; stb = 0;
    idle(1);

    wb(1, Base, 32'h8000_0004);
    idle(3);
    rst = 1;
    step();
    rst = 0;
    chk("rst_mid_guard", act, 32'd0);
    wb(0, Base + 32'h4, 0);
    chk("status_after_rst", last_rd, 32'h0);

    for (int i = 0; i < 400; i++) begin
      op = int'($urandom_range(0, 9));
      d  = $urandom;
      case (op)
        0, 1, 2, 3: begin
          d[31] = (($urandom % 4) != 0);
          d[5:0] = 6'($urandom_range(0, 33));
          wb(1, Base, d);
        end
        4: begin
          d[7:0] = 8'($urandom_range(0, 4));
          wb(1, Base + 32'h8, d);
        end
        5: wb(1, Base + 32'h4, d);
        6: wb(0, Base + {28'd0, 2'($urandom), 2'd0}, d);
        7: idle(int'($urandom_range(0, 6)));
        8: wb(($urandom % 2) == 1, Base ^ (32'h100 << $urandom_range(0, 23)), d);
        default: begin
          if (($urandom % 4) == 0) begin
            rst = 1;
            step();
            rst = 0;
          end
          idle(1);
        end
      endcase
    end
    idle(25);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
